mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit with its own sequencer for the 5-stage pipeline.
- Owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and models multi-cycle latency with a busy counter.
- Raises a stall request consumed by the pipeline stall logic, alongside the existing D-stage hazard stall, whenever a D-stage HI/LO-class instruction would collide with an in-flight operation.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..31)
DIV_CYCLES, 10, busy cycles for div/divu when MDU_ITER_DIV_EN is undefined (legal range 1..31)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  E stage holds a valid mult/multu/div/divu this cycle
md_op  input  4  MDOp code of the E-stage instruction
a  input  32  forwarded E-stage rs value
b  input  32  forwarded E-stage rt value
d_uses_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  operation in flight
hi  output  32  HI register, read by mfhi in E stage
lo  output  32  LO register, read by mflo in E stage
md_stall  output  1  combinational: d_uses_md & (start | busy)

Behaviour:
- Reset: hi=0, lo=0, busy=0, state=IDLE, counter=0. md_stall follows its inputs, so it is 0 when d_uses_md=0.
- States: IDLE, RUN. Counter is 5 bits.
- IDLE, start=1 at edge t, md_op in {MULT, MULTU, DIV, DIVU}:
  - latch a, b and md_op;
  - counter <= MULT_CYCLES or DIV_CYCLES, depending on op;
  - go to RUN.
- Timing of an operation started at edge t: busy=1 for cycles t+1 through t+N. HI/LO load at edge t+N. busy=0 and new hi/lo are visible from cycle t+N+1.
- RUN: counter decrements each edge. On the edge where counter==1, write the results, clear busy and return to IDLE.
- mult: {hi,lo} = signed a × signed b, 64 bits. multu: same product, unsigned.
- div and divu:
  - lo = quotient, truncated toward zero; hi = remainder, taking the sign of the dividend;
  - signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: full latency is still spent; hi and lo are left unchanged.
- mthi/mtlo in IDLE: hi (resp. lo) <= a at the same edge. No busy, no latency.
- mfhi/mflo do not involve this block beyond the hi/lo outputs.
- start=1 or mthi/mtlo while in RUN is ignored; md_stall guarantees this cannot occur. Benches flag it with an assertion.
- md_op=NONE with start=1 is ignored.
- Asynchronous reset mid-RUN aborts the operation: hi/lo are cleared and busy drops immediately.
- The md_stall term on start covers the cycle in which busy is not yet high.

Optional Feature:
- Macro: MDU_ITER_DIV_EN.
- Defined:
  - div/divu use a restoring radix-2 sub-module, one quotient bit per cycle; DIV_CYCLES is ignored.
  - Busy lasts exactly 32 cycles: t+1 through t+32, with results at edge t+32.
  - Signed div: operand magnitudes in, result signs fixed on completion.
  - Divide by zero still leaves hi/lo unchanged.
- Undefined: division is computed behaviourally at start and delayed by the counter.
- Multiply is identical in both builds.

Decomposition:
- Shared definitions file gains MDOp_none, MDOp_mult, MDOp_multu, MDOp_div, MDOp_divu, MDOp_mthi and MDOp_mtlo. Width is 4 bits.
- The controller decodes md_op, start and d_uses_md from the instruction.
- One sub-module, md_divider, is instantiated only under MDU_ITER_DIV_EN. Ports: clk, reset, go, sign, dividend, divisor, done, quotient, remainder.

Test Plan:
- mult, a=0xFFFFFFFE (−2), b=3, start at edge t -> busy cycles t+1 through t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after MULT_CYCLES.
- div, a=−7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu, a=7, b=0 -> busy for the full latency; hi/lo keep their prior values.
- mthi, a=0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0. Then issue a mult with d_uses_md=1 -> md_stall=1 in the start cycle and through all busy cycles, 0 the cycle busy falls.
- Assert reset during RUN at cycle 3 -> busy=0, hi=lo=0 immediately. A new start after reset releases completes normally.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp codes, sequencer states
// and the restoring-division step used when MDU_ITER_DIV_EN is defined.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDOp_none  = 4'd0,
    MDOp_mult  = 4'd1,
    MDOp_multu = 4'd2,
    MDOp_div   = 4'd3,
    MDOp_divu  = 4'd4,
    MDOp_mthi  = 4'd5,
    MDOp_mtlo  = 4'd6
  } md_op_e;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // One radix-2 restoring step; returns {remainder, quotient} after shifting in quo[31].
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dsr);
    logic [32:0] sh;
    sh = {rem, quo[31]};
    if (sh >= {1'b0, dsr}) begin
      sh = sh - {1'b0, dsr};
      return {sh[31:0], quo[30:0], 1'b1};
    end
    return {sh[31:0], quo[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/mdu_ctrl_divider.sv
// Iterative 32-cycle restoring divider (md_divider), built only with MDU_ITER_DIV_EN.
// Operates on magnitudes; quotient/remainder signs are applied at the outputs.
module md_divider
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        active;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, dsr;
  logic        neg_q, neg_r;
  logic [31:0] dvd_mag, dsr_mag;
  logic [63:0] first_step, next_step;

  assign dvd_mag    = (sign && dividend[31]) ? -dividend : dividend;
  assign dsr_mag    = (sign && divisor[31])  ? -divisor  : divisor;
  // The first quotient bit is produced on the go edge so 32 bits are ready 32 edges later.
  assign first_step = div_step(32'd0, dvd_mag, dsr_mag);
  assign next_step  = div_step(rem, quo, dsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= 5'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      dsr    <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (go) begin
      active     <= 1'b1;
      cnt        <= 5'd31;
      {rem, quo} <= first_step;
      dsr        <= dsr_mag;
      neg_q      <= sign & (dividend[31] ^ divisor[31]);
      neg_r      <= sign & dividend[31];
    end else if (active) begin
      if (cnt != 5'd0) begin
        {rem, quo} <= next_step;
        cnt        <= cnt - 5'd1;
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done      = active && (cnt == 5'd0);
  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning HI/LO. Optional macro MDU_ITER_DIV_EN selects an
// iterative 32-cycle divider instead of a behavioural divide delayed by DIV_CYCLES.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_uses_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall,
  output mdu_state_e  dbg_state
);

`ifdef MDU_ITER_DIV_EN
  // 32 truncates to 0 in the 5-bit counter; wrapping through 31..1 still gives 32 busy cycles.
  localparam int DIV_LAT = 32;
`else
  localparam int DIV_LAT = DIV_CYCLES;
`endif

  mdu_state_e         state, state_n;
  logic [4:0]         cnt, cnt_n;
  logic               is_mul, is_div, in_idle, accept, finish;
  logic signed [63:0] a_sx, b_sx;
  logic [63:0]        prod;
  logic [31:0]        res_hi, res_lo, res_hi_n, res_lo_n, fin_hi, fin_lo;
  logic               res_wr, res_wr_n, fin_wr;

  assign is_mul  = start && (md_op == MDOp_mult || md_op == MDOp_multu);
  assign is_div  = start && (md_op == MDOp_div  || md_op == MDOp_divu);
  assign in_idle = (state == MDU_IDLE);
  assign accept  = in_idle && (is_mul || is_div);
  assign finish  = (state == MDU_RUN) && (cnt == 5'd1);

  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};
  assign prod = (md_op == MDOp_mult) ? a_sx * b_sx : {32'd0, a} * {32'd0, b};

`ifndef MDU_ITER_DIV_EN
  logic        div_zero;
  logic [31:0] b_safe, q_s, r_s, q_u, r_u;
  assign div_zero = (b == 32'd0);
  // A divisor of 1 turns 0x80000000 / -1 into the required 0x80000000 rem 0 and avoids /0.
  assign b_safe = (div_zero || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'd1 : b;
  assign q_s    = $signed(a) / $signed(b_safe);
  assign r_s    = $signed(a) % $signed(b_safe);
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;
`endif

  always_comb begin
    res_hi_n = prod[63:32];
    res_lo_n = prod[31:0];
    res_wr_n = 1'b1;
`ifdef MDU_ITER_DIV_EN
    if (is_div) res_wr_n = (b != 32'd0);
`else
    if (md_op == MDOp_div) begin
      res_hi_n = r_s;
      res_lo_n = q_s;
      res_wr_n = !div_zero;
    end else if (md_op == MDOp_divu) begin
      res_hi_n = r_u;
      res_lo_n = q_u;
      res_wr_n = !div_zero;
    end
`endif
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      MDU_IDLE: if (accept) begin
        state_n = MDU_RUN;
        cnt_n   = is_mul ? 5'(MULT_CYCLES) : 5'(DIV_LAT);
      end
      MDU_RUN: begin
        cnt_n = cnt - 5'd1;
        if (cnt == 5'd1) state_n = MDU_IDLE;
      end
      default: state_n = MDU_IDLE;
    endcase
  end

`ifdef MDU_ITER_DIV_EN
  logic        op_div_q, dv_done;
  logic [31:0] dv_q, dv_r;

  md_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .go        (accept && is_div),
    .sign      (md_op == MDOp_div),
    .dividend  (a),
    .divisor   (b),
    .done      (dv_done),
    .quotient  (dv_q),
    .remainder (dv_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       op_div_q <= 1'b0;
    else if (accept) op_div_q <= is_div;
  end

  assign fin_hi = op_div_q ? dv_r : res_hi;
  assign fin_lo = op_div_q ? dv_q : res_lo;
  assign fin_wr = res_wr && (!op_div_q || dv_done);
`else
  assign fin_hi = res_hi;
  assign fin_lo = res_lo;
  assign fin_wr = res_wr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MDU_IDLE;
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        res_hi <= res_hi_n;
        res_lo <= res_lo_n;
        res_wr <= res_wr_n;
      end
      if (finish && fin_wr) begin
        hi <= fin_hi;
        lo <= fin_lo;
      end else if (in_idle && md_op == MDOp_mthi) begin
        hi <= a;
      end else if (in_idle && md_op == MDOp_mtlo) begin
        lo <= a;
      end
    end
  end

  assign busy      = (state == MDU_RUN);
  assign md_stall  = d_uses_md & (start | busy);
  assign dbg_state = state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl (default build): latency, HI/LO results, stall and reset abort.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a, b;
  logic        d_uses_md;
  logic        busy, md_stall;
  logic [31:0] hi, lo;
  mdu_state_e  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .md_stall  (md_stall),
    .dbg_state (dbg_state)
  );

  // New work must never be presented while an operation is in flight.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(busy && (start || md_op == MDOp_mthi || md_op == MDOp_mtlo)))
      else begin
        n_fail++;
        $error("FAIL protocol: new md op presented while busy");
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic du,
                        input logic [63:0] exp_hilo);
    int n;
    exp_q.push_back(exp_hilo);
    @(negedge clk);
    start = 1'b1; md_op = op; a = av; b = bv; d_uses_md = du;
    #1;
    check({tag, "_stall_start"}, 64'(md_stall), 64'(du));
    @(negedge clk);
    start = 1'b0; md_op = MDOp_none;
    #1;
    n = 0;
    while (busy && n < 64) begin
      if (n == 0) check({tag, "_state_run"}, 64'(dbg_state), 64'(MDU_RUN));
      if (du) check({tag, "_stall_busy"}, 64'(md_stall), 64'd1);
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
    check({tag, "_state_idle"}, 64'(dbg_state), 64'(MDU_IDLE));
    if (du) check({tag, "_stall_drop"}, 64'(md_stall), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp_q.pop_front());
    d_uses_md = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    longint      ps;
    logic [63:0] pu;

    reset = 1'b1; start = 1'b0; md_op = MDOp_none; a = '0; b = '0; d_uses_md = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_stall", 64'(md_stall), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(MDU_IDLE));
    reset = 1'b0;

    run_op("mult_neg",  MDOp_mult,  32'hFFFF_FFFE, 32'd3, MULT_N, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu_max", MDOp_multu, 32'hFFFF_FFFF, 32'd2, MULT_N, 1'b0, 64'h0000_0001_FFFF_FFFE);
    run_op("div_neg",   MDOp_div,   32'hFFFF_FFF9, 32'd2, DIV_N,  1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", MDOp_divu,  32'd7,         32'd0, DIV_N,  1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf",   MDOp_div,   32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 1'b0, 64'h0000_0000_8000_0000);
    run_op("divu_100",  MDOp_divu,  32'd100,       32'd7, DIV_N,  1'b0, 64'h0000_0002_0000_000E);

    // start with md_op=NONE is ignored
    @(negedge clk); start = 1'b1; md_op = MDOp_none;
    @(negedge clk); start = 1'b0; #1;
    check("none_busy", 64'(busy), 64'd0);
    check("none_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    @(negedge clk); md_op = MDOp_mthi; a = 32'h1234;
    @(negedge clk); md_op = MDOp_mtlo; a = 32'h55; #1;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk); md_op = MDOp_none; d_uses_md = 1'b1; #1;
    check("mtlo_hilo", {hi, lo}, 64'h0000_1234_0000_0055);
    check("idle_stall", 64'(md_stall), 64'd0);
    d_uses_md = 1'b0;

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      ps = longint'(signed'(ra)) * longint'(signed'(rb));
      pu = {32'd0, ra} * {32'd0, rb};
      run_op("mult_rand",  MDOp_mult,  ra, rb, MULT_N, 1'b0, 64'(ps));
      run_op("multu_rand", MDOp_multu, ra, rb, MULT_N, 1'b0, pu);
    end

    run_op("mult_stall", MDOp_mult, 32'h0001_0000, 32'h0001_0000, MULT_N, 1'b1, 64'h0000_0001_0000_0000);

    // Abort a mult in its third busy cycle
    @(negedge clk); start = 1'b1; md_op = MDOp_mult; a = 32'd9; b = 32'd9;
    @(negedge clk); start = 1'b0; md_op = MDOp_none;
    @(negedge clk); @(negedge clk);
    #1;
    check("abort_busy_pre", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_state", 64'(dbg_state), 64'(MDU_IDLE));
    @(negedge clk); reset = 1'b0;

    run_op("post_rst", MDOp_mult, 32'd7, 32'd6, MULT_N, 1'b0, 64'h0000_0000_0000_002A);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
